issue_ctrl: RTL and testbench

Fetch/decode/issue control stage directly upstream of the execute units (alu, branch, data_mov). Holds the PC and fetches one 32-bit instruction from instruction memory over a req/valid handshake. Decodes the instruction into operand selects and an immediate, then drives exactly one execute-unit enable. Sequences the PC from the branch result and holds the data-move enable until that unit reports completion.

---
 rtl/issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_issue_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Fetch/decode/issue control: fetches one instruction per request, decodes it and drives one execute-unit enable.
// Optional HALT instruction (unit 11, opcode 111) is compiled in with `define ISSUE_CTRL_HALT_EN.
module issue_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned DM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic        alu_en,
    output logic        br_en,
    output logic        dm_en,
    output logic [2:0]  opcode,
    output logic        has_imm,
    output logic [4:0]  rd_sel,
    output logic [4:0]  rs1_sel,
    output logic [4:0]  rs2_sel,
    output logic [20:0] imm,
    input  logic        br_taken,
    input  logic [20:0] br_offset,
    input  logic        dm_done,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        err,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [7:0] DM_LIMIT = 8'(DM_TIMEOUT);

    state_t      state;
    logic [31:0] ir;
    logic [7:0]  dm_cnt;
    logic [1:0]  unit;
    logic [31:0] pc_seq;
    logic [31:0] br_target;

    assign unit      = ir[31:30];
    assign pc_seq    = pc + 32'd4;
    // Taken target is word aligned regardless of the offset's low bits.
    assign br_target = (pc + {{11{br_offset[20]}}, br_offset}) & 32'hFFFF_FFFC;

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign opcode    = ir[29:27];
    assign has_imm   = ir[26];
    assign rd_sel    = ir[25:21];
    assign rs1_sel   = ir[20:16];
    assign rs2_sel   = ir[15:11];
    assign imm       = ir[26] ? ir[20:0] : '0;

`ifdef ISSUE_CTRL_HALT_EN
    logic halt_q;
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            alu_en <= 1'b0;
            br_en  <= 1'b0;
            dm_en  <= 1'b0;
            rf_we  <= 1'b0;
            err    <= 1'b0;
            dm_cnt <= '0;
`ifdef ISSUE_CTRL_HALT_EN
            halt_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (unit)
                        2'b00: begin
                            alu_en <= 1'b1;
                            rf_we  <= 1'b1;
                            state  <= S_EXEC;
                        end
                        2'b01: begin
                            br_en <= 1'b1;
                            state <= S_EXEC;
                        end
                        2'b10: begin
                            dm_en  <= 1'b1;
                            dm_cnt <= '0;
                            state  <= S_EXEC;
                        end
                        default: begin
`ifdef ISSUE_CTRL_HALT_EN
                            if (ir[29:27] == 3'b111) begin
                                halt_q <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                pc    <= pc_seq;
                                state <= S_FETCH;
                            end
`else
                            pc    <= pc_seq;
                            state <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_EXEC: begin
                    case (unit)
                        2'b00: begin
                            alu_en <= 1'b0;
                            rf_we  <= 1'b0;
                            pc     <= pc_seq;
                            state  <= S_FETCH;
                        end
                        2'b01: begin
                            br_en <= 1'b0;
                            pc    <= br_taken ? br_target : pc_seq;
                            state <= S_FETCH;
                        end
                        default: begin
                            // Completion wins over a timeout landing in the same cycle.
                            if (dm_done) begin
                                dm_en <= 1'b0;
                                pc    <= pc_seq;
                                state <= S_FETCH;
                            end else if (dm_cnt + 8'd1 == DM_LIMIT) begin
                                dm_en  <= 1'b0;
                                err    <= 1'b1;
                                dm_cnt <= dm_cnt + 8'd1;
                                pc     <= pc_seq;
                                state  <= S_FETCH;
                            end else begin
                                dm_cnt <= dm_cnt + 8'd1;
                            end
                        end
                    endcase
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: transaction-level reference model tracking pc/err per instruction.
// Honours ISSUE_CTRL_HALT_EN the same way as the design.
module tb_issue_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          DMT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        alu_en, br_en, dm_en;
    logic [2:0]  opcode;
    logic        has_imm;
    logic [4:0]  rd_sel, rs1_sel, rs2_sel;
    logic [20:0] imm;
    logic        br_taken;
    logic [20:0] br_offset;
    logic        dm_done;
    logic        rf_we;
    logic [31:0] pc;
    logic        err, halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_err;

    issue_ctrl #(.RESET_PC(RPC), .DM_TIMEOUT(DMT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_en(alu_en), .br_en(br_en), .dm_en(dm_en),
        .opcode(opcode), .has_imm(has_imm),
        .rd_sel(rd_sel), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .imm(imm),
        .br_taken(br_taken), .br_offset(br_offset), .dm_done(dm_done),
        .rf_we(rf_we), .pc(pc), .err(err), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        imem_valid = 1'b0;
        dm_done = 1'b0;
        br_taken = 1'b0;
        br_offset = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = RPC;
        m_err = 1'b0;
    endtask

    // Executes one instruction; the model predicts its whole effect from the encoding.
    task automatic run_instr(input logic [31:0] ins, input logic taken, input logic [20:0] off,
                             input int done_at, input int delay);
        int n_alu = 0, n_br = 0, n_dm = 0, n_we = 0;
        int first_en = -1, back = -1, low_before = 0, stray = 0, dec_bad = 0;
        int exp_dm = 0, exp_back, exp_first;
        logic exp_to = 1'b0;
        logic [31:0] exp_pc, sext;
        logic [1:0] u;
        logic [57:0] exp_dec;
        u = ins[31:30];
        sext = {{11{off[20]}}, off};
        exp_pc = m_pc + 32'd4;
        exp_first = 2;
        exp_back = 3;
        case (u)
            2'd1: if (taken) exp_pc = (m_pc + sext) & ~32'd3;
            2'd2: begin
                if (done_at >= 1 && done_at <= DMT) exp_dm = done_at;
                else begin exp_dm = DMT; exp_to = 1'b1; end
                exp_back = 2 + exp_dm;
            end
            2'd3: begin exp_back = 2; exp_first = -1; end
            default: ;
        endcase
        exp_dec = {ins[29:27], ins[26], ins[25:21], ins[20:16], ins[15:11],
                   (ins[26] ? ins[20:0] : 21'd0)};
        br_taken = taken;
        br_offset = off;
        dm_done = 1'b0;

        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        if (alu_en || br_en || dm_en || rf_we) stray++;
        low_before++;
        for (int d = 0; d < delay; d++) begin
            imem_valid = 1'b0;
            @(posedge clk); #1;
            if (!imem_req || alu_en || br_en || dm_en || rf_we) stray++;
            low_before++;
        end
        imem_valid = 1'b1;
        imem_data = ins;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        imem_data = $urandom;

        for (int i = 1; i <= 300; i++) begin
            if (i > 1 && imem_req) begin back = i; break; end
            if (imem_req) stray++;
            if ({opcode, has_imm, rd_sel, rs1_sel, rs2_sel, imm} !== exp_dec) dec_bad++;
            if (int'(alu_en) + int'(br_en) + int'(dm_en) > 1) stray++;
            if (rf_we && !alu_en) stray++;
            if (alu_en || br_en || dm_en) begin
                if (first_en < 0) first_en = i;
            end else if (first_en < 0) begin
                low_before++;
            end
            n_alu += int'(alu_en);
            n_br  += int'(br_en);
            n_dm  += int'(dm_en);
            n_we  += int'(rf_we);
            dm_done = dm_en && (n_dm == done_at);
            @(posedge clk); #1;
        end
        dm_done = 1'b0;

        checks++;
        if (back !== exp_back) begin
            errors++;
            $display("FAIL return_cycle: ins=%h back at %0d, required %0d", ins, back, exp_back);
        end
        checks++;
        if (first_en !== exp_first) begin
            errors++;
            $display("FAIL issue_latency: ins=%h first enable at %0d, required %0d", ins, first_en, exp_first);
        end
        checks++;
        if (n_alu !== (u == 2'd0 ? 1 : 0) || n_we !== (u == 2'd0 ? 1 : 0) ||
            n_br !== (u == 2'd1 ? 1 : 0) || n_dm !== exp_dm) begin
            errors++;
            $display("FAIL enable_counts: ins=%h alu=%0d we=%0d br=%0d dm=%0d, required dm=%0d unit=%0d",
                     ins, n_alu, n_we, n_br, n_dm, exp_dm, u);
        end
        checks++;
        if (dec_bad !== 0) begin
            errors++;
            $display("FAIL decode: ins=%h %0d bad cycles, required 0", ins, dec_bad);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL protocol: ins=%h %0d stray/overlap events, required 0", ins, stray);
        end
        if (u == 2'd2) begin
            checks++;
            if (low_before < 2) begin
                errors++;
                $display("FAIL dm_gap: dm_en low %0d cycles before issue, required >=2", low_before);
            end
        end
        m_pc = exp_pc;
        m_err = m_err | exp_to;
        checks++;
        if (pc !== m_pc || err !== m_err || halted !== 1'b0) begin
            errors++;
            $display("FAIL result: ins=%h pc=%h err=%0b halted=%0b, required pc=%h err=%0b halted=0",
                     ins, pc, err, halted, m_pc, m_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== RPC || imem_addr !== RPC || imem_req !== 1'b1 ||
            {alu_en, br_en, dm_en, rf_we, err, halted} !== 6'b0 || opcode !== 3'd0 || imm !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%0b en=%b we=%0b err=%0b halted=%0b, required pc=%h req=1 rest 0",
                     pc, imem_req, {alu_en, br_en, dm_en}, rf_we, err, halted, RPC);
        end
    endtask

    task automatic test_alu();
        run_instr(32'h0A21_0000, 1'b0, '0, 0, 0);
        run_instr(32'h0C00_1234, 1'b0, '0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr(32'h4000_0000, 1'b1, 21'h0000FC, 0, 0);
        run_instr(32'h4000_0000, 1'b1, 21'h1FFFF0, 0, 0);
        run_instr(32'h4000_0000, 1'b1, 21'h000010, 0, 0);
        run_instr(32'h4000_0000, 1'b0, 21'h1FFFF0, 0, 0);
        run_instr(32'h4000_0000, 1'b1, 21'h000013, 0, 0);
    endtask

    task automatic test_wrap();
        run_instr(32'h4000_0000, 1'b1, 21'(-(int'(m_pc) + 4)), 0, 0);
        run_instr(32'h0000_0000, 1'b0, '0, 0, 0);
        run_instr(32'h4000_0000, 1'b1, 21'h1FFFF8, 0, 0);
        run_instr(32'h4000_0000, 1'b1, 21'h000108, 0, 0);
    endtask

    task automatic test_data_mov();
        run_instr(32'h8000_0000, 1'b0, '0, 3, 0);
        run_instr(32'h8421_0000, 1'b0, '0, 1, 0);
        run_instr(32'h8000_0000, 1'b0, '0, DMT, 0);
    endtask

    task automatic test_dm_timeout();
        run_instr(32'h8000_0000, 1'b0, '0, 0, 0);
        run_instr(32'h0000_0000, 1'b0, '0, 0, 0);
        run_instr(32'h8000_0000, 1'b0, '0, 2, 0);
    endtask

    task automatic test_fetch_stall();
        run_instr(32'h0842_0000, 1'b0, '0, 0, 10);
    endtask

    task automatic test_reset_mid_dm();
        imem_valid = 1'b1;
        imem_data = 32'h8000_0000;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (dm_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_dm_active: dm_en=%0b, required 1", dm_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RPC;
        m_err = 1'b0;
        checks++;
        if (dm_en !== 1'b0 || pc !== RPC || imem_req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_dm: dm_en=%0b pc=%h req=%0b err=%0b, required 0 %h 1 0",
                     dm_en, pc, imem_req, err, RPC);
        end
    endtask

    task automatic test_halt();
`ifdef ISSUE_CTRL_HALT_EN
        int bad = 0;
        logic [31:0] hold_pc;
        hold_pc = m_pc;
        imem_valid = 1'b1;
        imem_data = 32'hF800_0000;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== hold_pc || alu_en || br_en || dm_en) bad++;
            imem_valid = 1'(i & 1);
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL halt_hold: %0d bad cycles, required 0", bad);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RPC;
        m_err = 1'b0;
        checks++;
        if (halted !== 1'b0 || pc !== RPC || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset: halted=%0b pc=%h req=%0b, required 0 %h 1", halted, pc, imem_req, RPC);
        end
        run_instr(32'hF000_0000, 1'b0, '0, 0, 0);
`else
        run_instr(32'hF800_0000, 1'b0, '0, 0, 0);
        run_instr(32'hC000_0000, 1'b0, '0, 0, 1);
`endif
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
`ifdef ISSUE_CTRL_HALT_EN
            if (ins[31:27] == 5'b11111) ins[27] = 1'b0;
`endif
            run_instr(ins, 1'($urandom_range(0, 1)), 21'($urandom),
                      int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_valid = 1'b0;
        imem_data = '0;
        br_taken = 1'b0;
        br_offset = '0;
        dm_done = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_wrap();
        test_data_mov();
        test_dm_timeout();
        test_fetch_stall();
        test_reset_mid_dm();
        test_halt();
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
